// File: rtl/rr_priority_arbiter.sv
`default_nettype none
// ============================================================================
// rr_priority_arbiter : round-robin arbiter, registered one-hot grant held
// until the owner releases; macro ARB_HOLD_TIMEOUT_EN bounds tenure. Rev 1.0
// ============================================================================
module rr_priority_arbiter #(
  parameter  int NUM_REQ  = 16,
  parameter  int HOLD_MAX = 64,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clkPort,
  input  logic               Reset,
  input  logic [NUM_REQ-1:0] requestSignals,
  // "release" is a reserved word, hence releaseIn
  input  logic               releaseIn,
  output logic [NUM_REQ-1:0] grantSignals,
  output logic               grantValid,
  output logic [IDX_W-1:0]   grantIdx,
  output logic               timeout
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 32) begin : g_bad_num_req
    $error("rr_priority_arbiter: NUM_REQ must be in 2..32");
  end
  if (HOLD_MAX < 2) begin : g_bad_hold_max
    $error("rr_priority_arbiter: HOLD_MAX must be at least 2");
  end

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  // Returns {found, index}: first set bit of cand at or above start, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                             input logic [IDX_W-1:0]   start);
    logic [IDX_W:0] res;
    int             pos;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = int'(start) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (cand[pos[IDX_W-1:0]]) res = {1'b1, pos[IDX_W-1:0]};
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;

  logic               w_owner_req;
  logic               w_vol_end;
  logic               w_hold_expired;
  logic               w_tenure_end;
  logic [IDX_W-1:0]   w_ptr_next;
  logic [IDX_W:0]     w_pick_idle;
  logic [IDX_W:0]     w_pick_hand;

  assign w_owner_req  = requestSignals[idx_q];
  assign w_vol_end    = releaseIn | ~w_owner_req;
  assign w_tenure_end = w_vol_end | w_hold_expired;
  assign w_ptr_next   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

  // The outgoing owner is masked so a still-requesting releaser sits out once.
  assign w_pick_idle  = rr_pick(requestSignals, ptr_q);
  assign w_pick_hand  = rr_pick(requestSignals & ~grant_q, w_ptr_next);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (w_pick_idle[IDX_W]) begin
          state_d = S_GRANT;
          idx_d   = w_pick_idle[IDX_W-1:0];
          grant_d = onehot(w_pick_idle[IDX_W-1:0]);
        end
      end
      S_GRANT: begin
        if (w_tenure_end) begin
          ptr_d = w_ptr_next;
          if (w_pick_hand[IDX_W]) begin
            idx_d   = w_pick_hand[IDX_W-1:0];
            grant_d = onehot(w_pick_hand[IDX_W-1:0]);
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clkPort or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
    end
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int             CNT_W    = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  // Revocation only when someone else is waiting; a lone owner just saturates.
  assign w_hold_expired = (state_q == S_GRANT) && (hold_cnt_q == CNT_LAST) &&
                          (|(requestSignals & ~grant_q));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    if (state_q == S_GRANT) begin
      if (w_tenure_end) begin
        hold_cnt_d = '0;
        timeout_d  = w_hold_expired & ~w_vol_end;
      end else if (hold_cnt_q != CNT_LAST) begin
        hold_cnt_d = hold_cnt_q + CNT_W'(1);
      end
    end else begin
      hold_cnt_d = '0;
    end
  end

  always_ff @(posedge clkPort or negedge Reset) begin
    if (!Reset) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign w_hold_expired = 1'b0;
  assign timeout        = 1'b0;
`endif

  assign grantSignals = grant_q;
  assign grantValid   = (state_q == S_GRANT);
  assign grantIdx     = idx_q;

  a_grant_onehot0: assert property (@(posedge clkPort) disable iff (!Reset)
    $onehot0(grantSignals));
  a_valid_matches: assert property (@(posedge clkPort) disable iff (!Reset)
    grantValid == (|grantSignals));
  a_idx_matches: assert property (@(posedge clkPort) disable iff (!Reset)
    grantSignals[grantIdx] == grantValid);

endmodule
`default_nettype wire

// File: tb/tb_rr_priority_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rr_priority_arbiter : directed self-checking bench for rr_priority_arbiter
// Rev 1.0
// ============================================================================
module tb_rr_priority_arbiter;
  localparam int N    = 16;
  localparam int HOLD = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         rel;
  logic [N-1:0] gnt;
  logic         gv;
  logic [3:0]   gidx;
  logic         tout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_priority_arbiter #(
    .NUM_REQ (N),
    .HOLD_MAX(HOLD)
  ) dut (
    .clkPort       (clk),
    .Reset         (rst_n),
    .requestSignals(req),
    .releaseIn     (rel),
    .grantSignals  (gnt),
    .grantValid    (gv),
    .grantIdx      (gidx),
    .timeout       (tout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 16'hFFFF;
    rel   = 1'b0;
    #2;
    check("reset_gnt",  32'(gnt),  32'h0);
    check("reset_gv",   32'(gv),   32'h0);
    check("reset_idx",  32'(gidx), 32'h0);
    check("reset_tout", 32'(tout), 32'h0);
    tick();
    tick();
    check("reset_hold_gnt", 32'(gnt), 32'h0);

    rst_n = 1'b1;
    tick();
    check("first_gnt", 32'(gnt),  32'h0001);
    check("first_idx", 32'(gidx), 32'd0);
    check("first_gv",  32'(gv),   32'h1);

    // Release by owner 0 hands off to 4, then 4 drops and grant wraps to 0
    req = 16'h0011;
    rel = 1'b1;
    tick();
    rel = 1'b0;
    check("handoff_gnt", 32'(gnt),  32'h0010);
    check("handoff_idx", 32'(gidx), 32'd4);
    req = 16'h0001;
    tick();
    check("wrap_gnt", 32'(gnt),  32'h0001);
    check("wrap_idx", 32'(gidx), 32'd0);

    req = 16'hFFFF;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("rot_hold_idx", 32'(gidx), 32'((k - 1) % 16));
      tick();
      check("rot_hold_gnt", 32'(gnt), 32'h1 << ((k - 1) % 16));
      rel = 1'b1;
      tick();
      rel = 1'b0;
      check("rot_next_idx", 32'(gidx), 32'(k % 16));
      check("rot_next_gv",  32'(gv),   32'h1);
    end

    // Lone requester 3: release causes exactly one idle cycle
    req = 16'h0008;
    tick();
    check("lone_gnt", 32'(gnt),  32'h0008);
    check("lone_idx", 32'(gidx), 32'd3);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    check("lone_idle_gv",  32'(gv),   32'h0);
    check("lone_idle_gnt", 32'(gnt),  32'h0);
    check("lone_idle_idx", 32'(gidx), 32'd3);
    tick();
    check("lone_regrant_gnt", 32'(gnt), 32'h0008);
    check("lone_regrant_gv",  32'(gv),  32'h1);

    // Asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt),  32'h0);
    check("async_rst_gv",  32'(gv),   32'h0);
    check("async_rst_idx", 32'(gidx), 32'h0);
    req = 16'h0006;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idx", 32'(gidx), 32'd1);
    check("post_rst_gnt", 32'(gnt),  32'h0002);

    // Owner 2 holds while 5 waits
    req = 16'h0004;
    tick();
    check("hold2_idx", 32'(gidx), 32'd2);
    req = 16'h0024;
`ifdef ARB_HOLD_TIMEOUT_EN
    for (int i = 0; i < HOLD - 1; i++) begin
      tick();
      check("to_wait_idx",  32'(gidx), 32'd2);
      check("to_wait_tout", 32'(tout), 32'h0);
    end
    tick();
    check("to_fire_idx",  32'(gidx), 32'd5);
    check("to_fire_gnt",  32'(gnt),  32'h0020);
    check("to_fire_tout", 32'(tout), 32'h1);
    tick();
    check("to_after_tout", 32'(tout), 32'h0);
    check("to_after_idx",  32'(gidx), 32'd5);
`else
    for (int i = 0; i < 10; i++) begin
      tick();
      check("nto_idx",  32'(gidx), 32'd2);
      check("nto_tout", 32'(tout), 32'h0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
